// File: rtl/janus_cpu_if.sv
// janus_cpu_if: word-addressed request/acknowledge memory bus between the janus core and RAM.
interface janus_cpu_if;
    logic [31:0] dib_janus;
    logic [2:0]  cb_in;
    logic [31:0] dob;
    logic [31:0] ab;
    logic [2:0]  cb_out;
    modport master (input dib_janus, cb_in, output dob, ab, cb_out);
    modport slave  (output dib_janus, cb_in, input dob, ab, cb_out);
endinterface

// File: rtl/janus_cpu.sv
// janus_cpu: 32-bit multi-cycle load/store core sharing one request/acknowledge bus for fetch and data.
module janus_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_janus,
    input  logic         rst_janus_b,
    janus_cpu_if.master  bus,
    output logic         halt
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] MEM    = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;
    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] READ  = 3'b001;
    localparam logic [2:0] WRITE = 3'b010;
    localparam logic [2:0] RDACK = 3'b001;
    localparam logic [2:0] WRACK = 3'b010;

    logic [1:0]  state;
    logic [31:0] pc, ir;
    logic [31:0] rf [16];
    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] simm, rd_v, rs1_v, rs2_v, alu, next_pc, addr;
    logic        wr, taken, acked;

    always_comb begin
        op      = ir[31:28];
        rd      = ir[27:24];
        rs1     = ir[23:20];
        rs2     = ir[19:16];
        simm    = {{16{ir[15]}}, ir[15:0]};
        rd_v    = rf[rd];
        rs1_v   = rf[rs1];
        rs2_v   = rf[rs2];
        addr    = rs1_v + simm;
        case (op)
            4'h1:    alu = rs1_v + rs2_v;
            4'h2:    alu = rs1_v - rs2_v;
            4'h3:    alu = rs1_v & rs2_v;
            4'h4:    alu = rs1_v | rs2_v;
            4'h5:    alu = rs1_v ^ rs2_v;
            4'h7:    alu = {ir[15:0], 16'h0};
            4'hD:    alu = rs1_v << ir[4:0];
            4'hE:    alu = rs1_v >> ir[4:0];
            default: alu = addr;
        endcase
        wr      = (op >= 4'h1 && op <= 4'h7) || op == 4'hD || op == 4'hE;
        taken   = (op == 4'hA && rd_v == rs1_v) || (op == 4'hB && rd_v != rs1_v);
        next_pc = taken ? pc + 32'd1 + simm : op == 4'hC ? {16'h0, ir[15:0]} : pc + 32'd1;
        acked   = (bus.cb_out == READ && bus.cb_in == RDACK) || (bus.cb_out == WRITE && bus.cb_in == WRACK);
    end

    always_ff @(posedge clk_janus) begin
        if (!rst_janus_b) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            bus.cb_out <= IDLE;
            bus.ab     <= '0;
            bus.dob    <= '0;
            halt       <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (acked) begin
                        ir         <= bus.dib_janus;
                        bus.cb_out <= IDLE;
                        state      <= EXEC;
                    end else begin
                        bus.cb_out <= READ;
                        bus.ab     <= pc;
                    end
                end
                EXEC: begin
                    if (op == 4'h8 || op == 4'h9) begin
                        bus.ab     <= addr;
                        bus.cb_out <= op == 4'h8 ? READ : WRITE;
                        if (op == 4'h9) bus.dob <= rd_v;
                        state      <= MEM;
                    end else if (op == 4'hF) begin
                        halt  <= 1'b1;
                        state <= HALTED;
                    end else begin
                        // the IDLE cycle spent in EXEC separates this fetch from the previous one
                        if (wr && rd != 4'd0) rf[rd] <= alu;
                        pc         <= next_pc;
                        bus.ab     <= next_pc;
                        bus.cb_out <= READ;
                        state      <= FETCH;
                    end
                end
                MEM: begin
                    if (acked) begin
                        if (op == 4'h8 && rd != 4'd0) rf[rd] <= bus.dib_janus;
                        pc         <= pc + 32'd1;
                        bus.cb_out <= IDLE;
                        state      <= FETCH;
                    end
                end
                default: bus.cb_out <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_janus_cpu.sv
// tb_janus_cpu: directed and randomized programs checked against an instruction-level reference model.
module tb_janus_cpu;
    logic clk_janus = 1'b0;
    logic rst_janus_b = 1'b0;
    logic halt;
    janus_cpu_if bus();

    janus_cpu dut (.clk_janus(clk_janus), .rst_janus_b(rst_janus_b), .bus(bus), .halt(halt));

    always #5 clk_janus = ~clk_janus;

    logic [31:0] img [256];
    logic [31:0] ram [256];
    logic [31:0] mm  [256];
    int lat_fix = 0;
    bit rnd_lat = 1'b0;
    int lat, cnt;
    int vectors = 0, miscompares = 0;

    // RAM: copies the image while in reset, acks after `lat` idle cycles, one-cycle ack pulse
    always @(posedge clk_janus) begin
        if (!rst_janus_b) begin
            for (int i = 0; i < 256; i++) ram[i] <= img[i];
            bus.cb_in <= 3'b000;
            cnt <= 0;
            lat <= rnd_lat ? int'($urandom_range(0, 3)) : lat_fix;
        end else if (bus.cb_in != 3'b000) begin
            bus.cb_in <= 3'b000;
        end else if (bus.cb_out == 3'b001 || bus.cb_out == 3'b010) begin
            if (cnt >= lat) begin
                cnt <= 0;
                lat <= rnd_lat ? int'($urandom_range(0, 3)) : lat_fix;
                if (bus.cb_out == 3'b001) begin
                    bus.dib_janus <= ram[bus.ab[7:0]];
                    bus.cb_in <= 3'b001;
                end else begin
                    ram[bus.ab[7:0]] <= bus.dob;
                    bus.cb_in <= 3'b010;
                end
            end else cnt <= cnt + 1;
        end
    end

    // bus-protocol monitor: held requests, IDLE gap after each ack, silence once halted
    logic [2:0]  p_cb, p_cin;
    logic [31:0] p_ab, p_dob, w_ab, w_dob;
    logic        p_ok = 1'b0;
    int viol = 0;
    always @(negedge clk_janus) begin
        if (rst_janus_b && p_ok) begin
            if (p_cb != 3'b000 && p_cin == 3'b000 && (bus.cb_out !== p_cb || bus.ab !== p_ab || bus.dob !== p_dob)) viol++;
            if (p_cb != 3'b000 && p_cin != 3'b000 && bus.cb_out !== 3'b000) viol++;
            if (halt && bus.cb_out !== 3'b000) viol++;
        end
        if (bus.cb_out == 3'b010 && bus.cb_in == 3'b010) begin
            w_ab = bus.ab;
            w_dob = bus.dob;
        end
        p_ok = rst_janus_b;
        p_cb = bus.cb_out;
        p_cin = bus.cb_in;
        p_ab = bus.ab;
        p_dob = bus.dob;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // instruction-level interpreter over the initial image
    task automatic model_run();
        logic [31:0] r [16];
        logic [31:0] pc, ins, a, b, d, s, npc;
        logic [3:0]  rd;
        bit done;
        for (int i = 0; i < 256; i++) mm[i] = img[i];
        for (int i = 0; i < 16; i++) r[i] = 0;
        pc = 0;
        done = 0;
        for (int step = 0; step < 5000 && !done; step++) begin
            ins = mm[pc[7:0]];
            rd = ins[27:24];
            a = r[ins[23:20]];
            b = r[ins[19:16]];
            d = r[rd];
            s = {{16{ins[15]}}, ins[15:0]};
            npc = pc + 1;
            case (ins[31:28])
                4'h1: r[rd] = a + b;
                4'h2: r[rd] = a - b;
                4'h3: r[rd] = a & b;
                4'h4: r[rd] = a | b;
                4'h5: r[rd] = a ^ b;
                4'h6: r[rd] = a + s;
                4'h7: r[rd] = ins[15:0] * 32'h10000;
                4'h8: r[rd] = mm[8'(a + s)];
                4'h9: mm[8'(a + s)] = d;
                4'hA: if (d == a) npc = pc + 1 + s;
                4'hB: if (d != a) npc = pc + 1 + s;
                4'hC: npc = {16'h0, ins[15:0]};
                4'hD: r[rd] = a << ins[4:0];
                4'hE: r[rd] = a >> ins[4:0];
                4'hF: done = 1;
                default: ;
            endcase
            r[0] = 0;
            pc = npc;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    task automatic start();
        rst_janus_b = 1'b0;
        repeat (2) @(posedge clk_janus);
        #2 rst_janus_b = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halt && n < 20000) begin
            @(posedge clk_janus);
            n++;
        end
        #1 chk(tag, {31'h0, halt}, 32'h1);
        repeat (3) @(posedge clk_janus);
        #1;
    endtask

    task automatic run(input int l, input bit r, input string tag);
        lat_fix = l;
        rnd_lat = r;
        model_run();
        start();
        wait_halt(tag);
    endtask

    initial begin
        int n;
        bit found;
        logic [3:0] op;
        logic [3:0] ops [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hD, 4'hE, 4'h0};

        clear_img();
        img[0] = 32'h6100_0005; img[1] = 32'h6200_0007; img[2] = 32'h1312_0000;
        img[3] = 32'h9300_0010; img[4] = 32'hF000_0000;
        model_run();
        repeat (2) @(posedge clk_janus);
        #1 chk("rst_cb_out", {29'h0, bus.cb_out}, 32'h0);
        chk("rst_ab", bus.ab, 32'h0);
        #1 rst_janus_b = 1'b1;
        @(posedge clk_janus);
        #1 chk("first_cb_out", {29'h0, bus.cb_out}, 32'h1);
        chk("first_ab", bus.ab, 32'h0);
        chk("first_halt", {31'h0, halt}, 32'h0);
        chk("first_dob", bus.dob, 32'h0);
        wait_halt("p1_halt");
        chk("p1_wr_ab", w_ab, 32'h10);
        chk("p1_wr_dob", w_dob, 32'd12);
        chk("p1_mem16", ram[16], 32'd12);
        chk("p1_model16", ram[16], mm[16]);
        chk("p1_idle", {29'h0, bus.cb_out}, 32'h0);

        clear_img();
        img[0] = 32'h8400_0020; img[1] = 32'h9400_0021; img[2] = 32'hF000_0000;
        img[32'h20] = 32'hDEAD_BEEF;
        run(0, 1'b0, "ldst_halt");
        chk("ldst_mem21", ram[8'h21], 32'hDEAD_BEEF);

        clear_img();
        img[0] = 32'h6100_0003; img[1] = 32'h6110_FFFF; img[2] = 32'h6220_0001;
        img[3] = 32'hB100_FFFD; img[4] = 32'h9100_0030; img[5] = 32'h9200_0031;
        img[6] = 32'hF000_0000;
        run(0, 1'b0, "loop_halt");
        chk("loop_r1", ram[8'h30], 32'h0);
        chk("loop_iters", ram[8'h31], 32'd3);
        chk("loop_model", ram[8'h31], mm[8'h31]);

        clear_img();
        img[0] = 32'h6100_0005; img[1] = 32'h6200_0007; img[2] = 32'h1312_0000;
        img[3] = 32'h9300_0010; img[4] = 32'hF000_0000;
        run(4, 1'b0, "wait_halt");
        chk("wait_mem16", ram[16], 32'd12);

        for (int t = 0; t < 8; t++) begin
            clear_img();
            for (int i = 1; i < 16; i++) begin
                img[i - 1] = {4'h8, 4'(i), 4'h0, 4'h0, 16'(32'h90 + i)};
                img[32'h90 + i] = $urandom;
            end
            for (int i = 15; i < 40; i++) begin
                op = ops[$urandom_range(0, 9)];
                img[i] = {op, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)};
                if ($urandom_range(0, 5) == 0)
                    img[i] = {($urandom_range(0, 1) != 0) ? 4'hA : 4'hB, 4'($urandom), 4'($urandom), 4'h0, 16'($urandom_range(0, 1))};
            end
            for (int i = 1; i < 16; i++) img[39 + i] = {4'h9, 4'(i), 4'h0, 4'h0, 16'(32'hA0 + i)};
            img[55] = 32'hF000_0000;
            run(0, 1'b1, "rnd_halt");
            for (int i = 1; i < 16; i++) chk($sformatf("rnd%0d_r%0d", t, i), ram[32'hA0 + i], mm[32'hA0 + i]);
        end

        clear_img();
        img[0] = 32'h6400_0009; img[1] = 32'h8500_0020; img[2] = 32'hF000_0000;
        lat_fix = 6;
        rnd_lat = 1'b0;
        start();
        found = 0;
        n = 0;
        while (!found && n < 200) begin
            @(posedge clk_janus);
            #1 found = bus.cb_out == 3'b001 && bus.ab == 32'h20;
            n++;
        end
        chk("reach_mem", {31'h0, found}, 32'h1);
        clear_img();
        img[0] = 32'h9400_0041; img[1] = 32'hF000_0000;
        img[8'h41] = 32'h5555_5555;
        model_run();
        #1 rst_janus_b = 1'b0;
        @(posedge clk_janus);
        #1 chk("midrst_cb_out", {29'h0, bus.cb_out}, 32'h0);
        chk("midrst_ab", bus.ab, 32'h0);
        chk("midrst_halt", {31'h0, halt}, 32'h0);
        @(posedge clk_janus);
        #2 rst_janus_b = 1'b1;
        @(posedge clk_janus);
        #1 chk("restart_ab", bus.ab, 32'h0);
        chk("restart_cb_out", {29'h0, bus.cb_out}, 32'h1);
        wait_halt("restart_halt");
        chk("restart_r4", ram[8'h41], 32'h0);
        chk("restart_model", ram[8'h41], mm[8'h41]);

        chk("bus_protocol", 32'(viol), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
